// File: rtl/genius_control.sv
// Control FSM for the memory game: sequences setup, playback, user entry,
// round check and the result screen by strobing the datapath enables.
module genius_control #(
  parameter int P_RESULT_HOLD = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enter,
  input  logic       end_FPGA,
  input  logic       end_User,
  input  logic       end_time,
  input  logic       win,
  input  logic       match,
  output logic       R1,
  output logic       R2,
  output logic       E1,
  output logic       E2,
  output logic       E3,
  output logic       E4,
  output logic       SEL,
  output logic [2:0] state
);

  localparam int HOLD_W = $clog2(P_RESULT_HOLD + 1);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_SETUP = 3'd1,
    S_PREP  = 3'd2,
    S_SHOW  = 3'd3,
    S_PLAY  = 3'd4,
    S_CHECK = 3'd5,
    S_NEXT  = 3'd6,
    S_WIN   = 3'd7
  } state_t;

  state_t              state_reg, state_next;
  logic                result_reg, result_next;
  logic [HOLD_W-1:0]   hold_reg, hold_next;
  logic                enter_prev_reg;
  logic                press;

  // History resets high so a key held through reset never counts as a press.
  assign press = enter & ~enter_prev_reg;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_INIT;
      result_reg     <= 1'b0;
      hold_reg       <= '0;
      enter_prev_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      result_reg     <= result_next;
      hold_reg       <= hold_next;
      enter_prev_reg <= enter;
    end
  end

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    hold_next   = hold_reg;
    if (result_reg) begin
      // Result shares code 7; any other code alongside the result flag is illegal.
      if (state_reg != S_WIN) begin
        state_next  = S_INIT;
        result_next = 1'b0;
      end else if (hold_reg != '0) begin
        hold_next = hold_reg - HOLD_W'(1);
      end else if (press) begin
        state_next  = S_INIT;
        result_next = 1'b0;
      end
    end else begin
      case (state_reg)
        S_INIT:  state_next = S_SETUP;
        S_SETUP: if (press) state_next = S_PREP;
        S_PREP:  state_next = S_SHOW;
        S_SHOW:  if (end_FPGA) state_next = S_PLAY;
        S_PLAY: begin
          if (end_User) begin
            state_next = S_CHECK;
          end else if (end_time) begin
            state_next  = S_WIN;
            result_next = 1'b1;
            hold_next   = HOLD_W'(P_RESULT_HOLD);
          end
        end
        S_CHECK: begin
          if (match) begin
            state_next = S_NEXT;
          end else begin
            state_next  = S_WIN;
            result_next = 1'b1;
            hold_next   = HOLD_W'(P_RESULT_HOLD);
          end
        end
        S_NEXT:  state_next = S_WIN;
        S_WIN: begin
          // Evaluated one cycle after E4 so the round counter has updated.
          if (win) begin
            state_next  = S_WIN;
            result_next = 1'b1;
            hold_next   = HOLD_W'(P_RESULT_HOLD);
          end else begin
            state_next = S_PREP;
          end
        end
        default: state_next = S_INIT;
      endcase
    end
  end

  always_comb begin
    R1    = 1'b0;
    R2    = 1'b0;
    E1    = 1'b0;
    E2    = 1'b0;
    E3    = 1'b0;
    E4    = 1'b0;
    SEL   = 1'b0;
    state = state_reg;
    if (!result_reg) begin
      case (state_reg)
        S_INIT:  begin R1 = 1'b1; R2 = 1'b1; end
        S_SETUP: E1 = 1'b1;
        S_PREP:  begin R2 = 1'b1; SEL = 1'b1; end
        S_SHOW:  begin E3 = 1'b1; SEL = 1'b1; end
        S_PLAY:  begin E2 = 1'b1; SEL = 1'b1; end
        S_CHECK: SEL = 1'b1;
        S_NEXT:  begin E4 = 1'b1; SEL = 1'b1; end
        S_WIN:   SEL = 1'b1;
        default: begin R1 = 1'b1; R2 = 1'b1; end
      endcase
    end
  end

endmodule

// File: tb/tb_genius_control.sv
// Table-driven bench for genius_control with a short result hold; expected
// outputs flow through a scoreboard queue and are compared after each edge.
module tb_genius_control;

  logic       clk;
  logic       reset;
  logic       enter, end_fpga, end_user, end_time, win, match;
  logic       r1, r2, e1, e2, e3, e4, sel;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       enter, end_fpga, end_user, end_time, win, match;
    logic [2:0] exp_state;
    logic       exp_result;
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] sb[$];

  genius_control #(.P_RESULT_HOLD(4)) dut (
    .CLOCK_50(clk), .reset(reset), .enter(enter),
    .end_FPGA(end_fpga), .end_User(end_user), .end_time(end_time),
    .win(win), .match(match),
    .R1(r1), .R2(r2), .E1(e1), .E2(e2), .E3(e3), .E4(e4), .SEL(sel),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {state, R1, R2, E1, E2, E3, E4, SEL} from the state table.
  function automatic logic [9:0] exp_out(input logic [2:0] st, input logic res);
    logic [6:0] s;
    s = 7'b0;
    if (res) return {3'd7, 7'b0};
    case (st)
      3'd0: s = 7'b1100000;
      3'd1: s = 7'b0010000;
      3'd2: s = 7'b0100001;
      3'd3: s = 7'b0000101;
      3'd4: s = 7'b0001001;
      3'd5: s = 7'b0000001;
      3'd6: s = 7'b0000011;
      default: s = 7'b0000001;
    endcase
    return {st, s};
  endfunction

  task automatic add(input logic en, input logic ef, input logic eu, input logic et,
                     input logic w, input logic m, input logic [2:0] st, input logic res);
    vec_t v;
    v.enter = en; v.end_fpga = ef; v.end_user = eu; v.end_time = et;
    v.win = w; v.match = m; v.exp_state = st; v.exp_result = res;
    vecs.push_back(v);
  endtask

  task automatic compare(input string name, input int idx);
    logic [9:0] exp, act;
    exp = sb.pop_front();
    act = {state, r1, r2, e1, e2, e3, e4, sel};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got state=%0d R1R2E1E2E3E4SEL=%b, want state=%0d R1R2E1E2E3E4SEL=%b",
               name, idx, act[9:7], act[6:0], exp[9:7], exp[6:0]);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    enter = v.enter; end_fpga = v.end_fpga; end_user = v.end_user;
    end_time = v.end_time; win = v.win; match = v.match;
    sb.push_back(exp_out(v.exp_state, v.exp_result));
    @(posedge clk);
    #1;
    compare("step", idx);
    $display("step %0d: enter=%b fpga=%b user=%b time=%b win=%b match=%b -> state=%0d out=%b",
             idx, v.enter, v.end_fpga, v.end_user, v.end_time, v.win, v.match,
             state, {r1, r2, e1, e2, e3, e4, sel});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    //  en ef eu et w  m  state res
    add(1, 0, 0, 0, 0, 0, 3'd1, 0); // held through reset: no press
    add(1, 0, 0, 0, 0, 0, 3'd1, 0);
    add(1, 0, 0, 0, 0, 0, 3'd1, 0);
    add(0, 0, 0, 0, 0, 0, 3'd1, 0);
    add(1, 0, 0, 0, 0, 0, 3'd2, 0); // press -> Prep
    add(0, 0, 0, 0, 0, 0, 3'd3, 0);
    add(1, 0, 0, 0, 0, 0, 3'd3, 0); // enter ignored in Show
    add(0, 1, 0, 0, 0, 0, 3'd4, 0);
    add(0, 0, 0, 0, 0, 0, 3'd4, 0);
    add(0, 0, 1, 0, 0, 1, 3'd5, 0);
    add(0, 0, 0, 0, 0, 1, 3'd6, 0);
    add(0, 0, 0, 0, 0, 0, 3'd7, 0);
    add(0, 0, 0, 0, 0, 0, 3'd2, 0); // win=0 -> Prep
    add(0, 0, 0, 0, 0, 0, 3'd3, 0);
    add(0, 1, 0, 0, 0, 0, 3'd4, 0);
    add(0, 0, 1, 1, 0, 1, 3'd5, 0); // end_User beats end_time
    add(0, 0, 0, 0, 0, 1, 3'd6, 0);
    add(0, 0, 0, 0, 0, 0, 3'd7, 0);
    add(0, 0, 0, 0, 1, 0, 3'd7, 1); // win=1 -> Result, hold=4
    add(0, 0, 0, 0, 0, 0, 3'd7, 1);
    add(1, 0, 0, 0, 0, 0, 3'd7, 1); // press at cycle 2 ignored
    add(0, 0, 0, 0, 0, 0, 3'd7, 1);
    add(0, 0, 0, 0, 0, 0, 3'd7, 1);
    add(0, 0, 0, 0, 0, 0, 3'd7, 1);
    add(1, 0, 0, 0, 0, 0, 3'd0, 0); // press at cycle 6 -> Init
    add(0, 0, 0, 0, 0, 0, 3'd1, 0);
    add(1, 0, 0, 0, 0, 0, 3'd2, 0);
    add(0, 0, 0, 0, 0, 0, 3'd3, 0);
    add(0, 1, 0, 0, 0, 0, 3'd4, 0);
    add(0, 0, 0, 1, 0, 0, 3'd7, 1); // timeout -> Result
    add(0, 0, 0, 0, 0, 0, 3'd7, 1);
    add(0, 0, 0, 0, 0, 0, 3'd7, 1);
    add(0, 0, 0, 0, 0, 0, 3'd7, 1);
    add(0, 0, 0, 0, 0, 0, 3'd7, 1);
    add(1, 0, 0, 0, 0, 0, 3'd0, 0);
    add(0, 0, 0, 0, 0, 0, 3'd1, 0);
    add(1, 0, 0, 0, 0, 0, 3'd2, 0);
    add(0, 0, 0, 0, 0, 0, 3'd3, 0);
    add(0, 1, 0, 0, 0, 0, 3'd4, 0);
    add(0, 0, 1, 0, 0, 0, 3'd5, 0); // mismatch
    add(0, 0, 0, 0, 0, 0, 3'd7, 1);
    add(0, 0, 0, 0, 0, 0, 3'd7, 1);
    add(0, 0, 0, 0, 0, 0, 3'd7, 1);
    add(0, 0, 0, 0, 0, 0, 3'd7, 1);
    add(0, 0, 0, 0, 0, 0, 3'd7, 1);
    add(1, 0, 0, 0, 0, 0, 3'd0, 0);
    add(0, 0, 0, 0, 0, 0, 3'd1, 0);
    add(1, 0, 0, 0, 0, 0, 3'd2, 0);
    add(0, 0, 0, 0, 0, 0, 3'd3, 0); // ends in Show for async reset test

    reset = 1'b0; enter = 1'b1;
    end_fpga = 0; end_user = 0; end_time = 0; win = 0; match = 0;
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(exp_out(3'd0, 1'b0));
    compare("reset_hold", 0);
    $display("reset hold: state=%0d out=%b", state, {r1, r2, e1, e2, e3, e4, sel});

    @(negedge clk);
    reset = 1'b1;
    foreach (vecs[i]) apply(vecs[i], i);

    // Asynchronous reset between edges while in Show.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    sb.push_back(exp_out(3'd0, 1'b0));
    compare("async_reset", 0);
    $display("async reset in Show: state=%0d out=%b", state, {r1, r2, e1, e2, e3, e4, sel});

    @(negedge clk);
    reset = 1'b1; enter = 1'b0;
    sb.push_back(exp_out(3'd1, 1'b0));
    @(posedge clk);
    #1;
    compare("after_release", 0);
    $display("release: state=%0d out=%b", state, {r1, r2, e1, e2, e3, e4, sel});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
